alu_result_fifo: RTL and testbench

- Downstream stage of the ALU: tracks each exec request, captures the ALU's registered result one cycle later, and buffers it with its opcode and a divide-by-zero flag.
- Presents captured entries to the memory-write side through a first-word-fall-through valid/ready FIFO.
- Shares clk/reset with the ALU. Taps the ALU request bus (exec, oper, B) and res_out.

---
 rtl/alu_result_fifo.sv | 123 ++++++++++++
 tb/tb_alu_result_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: captures ALU results one cycle after each exec request and
// buffers them, together with opcode and divide-by-zero flag, in a
// first-word-fall-through FIFO for the memory-write side.
//
// Handshake: out_valid means the head entry on out_data/out_oper/out_div0 is
// meaningful; it is transferred on every rising edge where out_valid and
// out_ready are both high. out_valid does not depend on out_ready, and
// out_ready while out_valid is low has no effect.
module alu_result_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      exec,
  input  logic [2:0]                oper,
  input  logic [DATA_WIDTH-1:0]     b_in,
  input  logic [2*DATA_WIDTH-1:0]   res_in,
  output logic [2*DATA_WIDTH-1:0]   out_data,
  output logic [2:0]                out_oper,
  output logic                      out_div0,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CW-1:0]             count,
  output logic                      full,
  output logic                      overflow,
  output logic [7:0]                drop_cnt,
  input  logic                      ovf_clr
);

  localparam int RW = 2 * DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int EW = RW + 4;

  // Pending capture: the request sampled on the previous edge
  logic          pend_vld;
  logic [2:0]    pend_oper;
  logic          pend_div0;

  // Storage holds {oper, div0, data}; it is deliberately not reset
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] head;

  logic push;
  logic pop;
  logic do_write;
  logic drop;

  assign push     = pend_vld;
  assign pop      = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign do_write = push && (!full || pop);
  assign drop     = push && full && !pop;

  // Capture the opcode and div-by-zero condition of each exec; opcodes 5..7
  // leave the ALU result unchanged, so there is nothing to capture for them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld  <= 1'b0;
      pend_oper <= 3'd0;
      pend_div0 <= 1'b0;
    end else begin
      pend_vld  <= exec && (oper <= 3'd4);
      pend_oper <= oper;
      pend_div0 <= (oper == 3'd4) && (b_in == '0);
    end
  end

  // Write the ALU result produced by the previous request into storage
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {pend_oper, pend_div0, res_in};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      if (do_write && !pop)      count <= count + CW'(1);
      else if (pop && !do_write) count <= count - CW'(1);
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)                drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

  // Head outputs fall through from storage and are zeroed while empty
  always_comb begin
    head      = mem[rd_ptr];
    out_valid = (count != '0);
    full      = (count == CW'(DEPTH));
    out_data  = '0;
    out_oper  = 3'd0;
    out_div0  = 1'b0;
    if (out_valid) begin
      out_oper = head[EW-1 -: 3];
      out_div0 = head[RW];
      out_data = head[RW-1:0];
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo. The bench plays the ALU: after each
// exec edge it drives res_in with the hand-computed result of that request.
module tb_alu_result_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exec = 1'b0;
  logic [2:0]  oper = 3'd0;
  logic [7:0]  b_in = 8'd0;
  logic [15:0] res_in = 16'd0;
  logic [15:0] out_data;
  logic [2:0]  out_oper;
  logic        out_div0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  count;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  alu_result_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .exec(exec), .oper(oper), .b_in(b_in),
    .res_in(res_in), .out_data(out_data), .out_oper(out_oper),
    .out_div0(out_div0), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt),
    .ovf_clr(ovf_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One ALU request: sampled on the next edge, result driven right after it
  task automatic issue(input logic [2:0] op, input logic [7:0] b, input logic [15:0] res);
    exec = 1'b1; oper = op; b_in = b;
    cycle();
    exec = 1'b0; res_in = res;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(); cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", out_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if ({full, overflow, drop_cnt} !== 10'd0) begin errors++; $display("FAIL reset_flags got %0h exp 0", {full, overflow, drop_cnt}); end
    checks++; if ({out_data, out_oper, out_div0} !== 20'd0) begin errors++; $display("FAIL reset_head got %0h exp 0", {out_data, out_oper, out_div0}); end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_add();
    issue(3'd1, 8'd100, 16'd300);   // 200 + 100
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency got %0h exp 0", out_valid); end
    cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0h exp 1", out_valid); end
    checks++; if ({out_oper, out_div0, out_data} !== {3'd1, 1'b0, 16'd300}) begin errors++; $display("FAIL add_head got %0h exp %0h", {out_oper, out_div0, out_data}, {3'd1, 1'b0, 16'd300}); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL add_pop_count got %0d exp 0", count); end
    checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL add_pop_data got %0h exp 0", out_data); end
  endtask

  task automatic test_div();
    issue(3'd4, 8'd0, 16'hDEAD);    // 9 / 0 -> ALU error code
    issue(3'd4, 8'd3, 16'd3);       // 9 / 3
    cycle();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL div_count got %0d exp 2", count); end
    checks++; if ({out_oper, out_div0, out_data} !== {3'd4, 1'b1, 16'hDEAD}) begin errors++; $display("FAIL div0_head got %0h exp %0h", {out_oper, out_div0, out_data}, {3'd4, 1'b1, 16'hDEAD}); end
    out_ready = 1'b1;
    cycle();
    checks++; if ({out_oper, out_div0, out_data} !== {3'd4, 1'b0, 16'd3}) begin errors++; $display("FAIL div_head got %0h exp %0h", {out_oper, out_div0, out_data}, {3'd4, 1'b0, 16'd3}); end
    cycle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL div_empty got %0h exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    // A=16, B=16; opcodes 5..7 leave the ALU result at its previous value
    issue(3'd0, 8'd16, 16'd0);
    issue(3'd5, 8'd16, res_in);
    issue(3'd6, 8'd16, res_in);
    issue(3'd7, 8'd16, res_in);
    issue(3'd3, 8'd16, 16'd256);
    cycle();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", count); end
    checks++; if ({out_oper, out_div0, out_data} !== {3'd0, 1'b0, 16'd0} || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %0h exp 0", {out_valid, out_oper, out_div0, out_data}); end
    out_ready = 1'b1;
    cycle();
    checks++; if ({out_oper, out_div0, out_data} !== {3'd3, 1'b0, 16'd256}) begin errors++; $display("FAIL b2b_second got %0h exp %0h", {out_oper, out_div0, out_data}, {3'd3, 1'b0, 16'd256}); end
    cycle();
    out_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", count); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      issue(3'd1, 8'(i), 16'(200 + i));
      if (i < 8) exp_q.push_back({3'd1, 1'b0, 16'(200 + i)});
    end
    cycle();
    checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL ovf_full got count %0d full %0h exp 8 1", count, full); end
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop got %0h/%0d exp 1/2", overflow, drop_cnt); end
  endtask

  task automatic test_full_push_pop();
    logic [19:0] exp;
    issue(3'd2, 8'd5, 16'h0777);
    checks++; if ({out_oper, out_div0, out_data} !== exp_q[0]) begin errors++; $display("FAIL fpp_head got %0h exp %0h", {out_oper, out_div0, out_data}, exp_q[0]); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({3'd2, 1'b0, 16'h0777});
    checks++; if (count !== 4'd8 || drop_cnt !== 8'd2) begin errors++; $display("FAIL fpp_count got %0d/%0d exp 8/2", count, drop_cnt); end
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL ovf_clr got %0h/%0d exp 0/0", overflow, drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = exp_q.pop_front();
      checks++; if ({out_oper, out_div0, out_data} !== exp || out_valid !== 1'b1) begin errors++; $display("FAIL drain_%0d got %0h exp %0h", i, {out_oper, out_div0, out_data}, exp); end
      cycle();
    end
    out_ready = 1'b0;
    checks++; if (count !== 4'd0 || full !== 1'b0) begin errors++; $display("FAIL drain_empty got %0d exp 0", count); end
  endtask

  task automatic test_clr_vs_drop();
    for (int i = 0; i < 9; i++) issue(3'd1, 8'd1, 16'(i));
    cycle();
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL cvd_pre got %0d exp 1", drop_cnt); end
    issue(3'd1, 8'd1, 16'h0055);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin errors++; $display("FAIL cvd_drop_wins got %0h/%0d exp 1/1", overflow, drop_cnt); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) issue(3'd1, 8'd1, 16'(i + 1));
    cycle();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL rst_mid_pre got %0d exp 3", count); end
    issue(3'd1, 8'd2, 16'hBEEF);    // pending, not yet pushed
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL rst_async got %0h/%0d exp 0/0", out_valid, count); end
    cycle();
    reset = 1'b0;
    issue(3'd2, 8'd1, 16'h0042);    // exec already high at release
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_pend_dropped got %0d exp 0", count); end
    cycle();
    checks++; if (count !== 4'd1 || {out_oper, out_div0, out_data} !== {3'd2, 1'b0, 16'h0042}) begin errors++; $display("FAIL rst_recover got %0d %0h exp 1 %0h", count, {out_oper, out_div0, out_data}, {3'd2, 1'b0, 16'h0042}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_clr_vs_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
